// File: rtl/vram_pkg.sv
// Shared constants and FSM state encoding for the video RAM arbiter.
package vram_pkg;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int STALL_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        VGA_ACC,
        VGA_CAP,
        CPU_ACC,
        CPU_CAP
    } state_t;

endpackage

// File: rtl/vram_req_sync.sv
// Synchroniser for the pixel-domain fetch strobe plus a rising-edge detector.
// req_rise is a single cpu_clk pulse for each low-to-high transition of vga_req.
module vram_req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic cpu_clk,
    input  logic reset,
    input  logic vga_req,
    output logic req_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;

    // Flop chain into the cpu_clk domain, then one delay flop for edge detection
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], vga_req};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign req_rise = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the 6502 bus and the VGA fetch port.
// VGA wins at IDLE; an in-flight CPU access is never preempted.
// Optional: define VRAM_STALL_CNT_EN to add the stall_count output.
module vram_arbiter #(
    parameter int ADDR_W      = vram_pkg::ADDR_W,
    parameter int DATA_W      = vram_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_STALL_CNT_EN
    ,
    output logic [vram_pkg::STALL_W-1:0] stall_count
`endif
);

    import vram_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic              vga_rise;
    logic              vga_pend;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_dout_q;

    vram_req_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_req_sync (
        .cpu_clk (cpu_clk),
        .reset   (reset),
        .vga_req (vga_req),
        .req_rise(vga_rise)
    );

    // State register
    always_ff @(posedge cpu_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and RAM port decode
    always_comb begin
        state_nxt = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        cpu_ready = 1'b0;
        case (state)
            IDLE: begin
                if (vga_pend)                 state_nxt = VGA_ACC;
                else if (cpu_cs && !cpu_done) state_nxt = CPU_ACC;
            end
            VGA_ACC: begin
                ram_en    = 1'b1;
                ram_addr  = vga_addr;
                state_nxt = VGA_CAP;
            end
            VGA_CAP: begin
                state_nxt = IDLE;
            end
            CPU_ACC: begin
                ram_en    = 1'b1;
                ram_we    = cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_din;
                state_nxt = CPU_CAP;
            end
            CPU_CAP: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pending VGA request; a new edge in VGA_ACC wins over the clear
    always_ff @(posedge cpu_clk) begin
        if (reset)                 vga_pend <= 1'b0;
        else if (vga_rise)         vga_pend <= 1'b1;
        else if (state == VGA_ACC) vga_pend <= 1'b0;
    end

    // Blocks a second access while the CPU keeps cs high after ready
    always_ff @(posedge cpu_clk) begin
        if (reset)                 cpu_done <= 1'b0;
        else if (!cpu_cs)          cpu_done <= 1'b0;
        else if (state == CPU_CAP) cpu_done <= 1'b1;
    end

    // Capture registers for fetched VGA byte and CPU read data
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            vga_data   <= '0;
            cpu_dout_q <= '0;
        end else begin
            if (state == VGA_CAP)            vga_data   <= ram_rdata;
            if (state == CPU_CAP && !cpu_we) cpu_dout_q <= ram_rdata;
        end
    end

    // RAM data bypasses the capture register during the ready cycle so the
    // read byte is valid while cpu_ready=1; it is held afterwards.
    always_comb begin
        cpu_dout = cpu_dout_q;
        if (state == CPU_CAP && !cpu_we) cpu_dout = ram_rdata;
    end

`ifdef VRAM_STALL_CNT_EN
    // Saturating count of cycles the CPU waits for the RAM
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (cpu_cs && !cpu_done && state != CPU_ACC && state != CPU_CAP
                     && stall_count != '1) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule
